// File: rtl/clk_sync_lockstep.sv
// Lockstep clock generator: two gated half-rate core clocks kept in phase by pairing retirements.
// Optional macro CLK_SYNC_ATK_EN compiles in the clock-equivalence monitor behind atk_equiv_o.
module clk_sync_lockstep #(
  parameter int unsigned MAX_RETIRES = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic retire_1_i,
  input  logic retire_2_i,
  output logic clk_1_o,
  output logic clk_2_o,
  output logic retire_o,
  output logic finished_o,
  output logic atk_equiv_o
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_RETIRES);

  logic        clk_1, clk_2;
  logic        wait_1, wait_2;
  logic        retire_q;
  logic        finished_q;
  logic [15:0] count;

  logic        done;
  logic        sample_1, sample_2;
  logic        pair_done;
  logic        clk_1_d, clk_2_d;
  logic        wait_1_d, wait_2_d;
  logic [15:0] count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    count_d   = count;
    // Gating on the counter itself, not only the registered flag, keeps the clocks
    // from rising in the cycle between the last pair and finished_o asserting.
    done      = finished_q || (count == MAX_CNT);
    sample_1  = clk_1 && !wait_1 && retire_1_i && !done;
    sample_2  = clk_2 && !wait_2 && retire_2_i && !done;
    pair_done = (sample_1 && sample_2) || (sample_1 && wait_2) || (sample_2 && wait_1);

    // A sample only happens while the clock is high, so the toggle also drops it low.
    clk_1_d   = !done && !wait_1 && !clk_1;
    clk_2_d   = !done && !wait_2 && !clk_2;

    wait_1_d  = pair_done ? 1'b0 : (wait_1 || sample_1);
    wait_2_d  = pair_done ? 1'b0 : (wait_2 || sample_2);

    if (pair_done && (count != MAX_CNT)) count_d = count + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_1      <= 1'b0;
      clk_2      <= 1'b0;
      wait_1     <= 1'b0;
      wait_2     <= 1'b0;
      retire_q   <= 1'b0;
      finished_q <= 1'b0;
      count      <= '0;
    end else begin
      clk_1      <= clk_1_d;
      clk_2      <= clk_2_d;
      wait_1     <= wait_1_d;
      wait_2     <= wait_2_d;
      retire_q   <= pair_done;
      finished_q <= finished_q || (count == MAX_CNT);
      count      <= count_d;
    end
  end

`ifdef CLK_SYNC_ATK_EN
  logic atk_equiv;

  always_ff @(posedge clk_i) begin
    if (rst_i)               atk_equiv <= 1'b1;
    else if (clk_1 != clk_2) atk_equiv <= 1'b0;
  end

  assign atk_equiv_o = atk_equiv;
`else
  assign atk_equiv_o = 1'b1;
`endif

  assign clk_1_o    = clk_1;
  assign clk_2_o    = clk_2;
  assign retire_o   = retire_q;
  assign finished_o = finished_q;

endmodule

// File: tb/tb_clk_sync_lockstep.sv
// Directed bench for clk_sync_lockstep (MAX_RETIRES = 3); outputs sampled 1 ns after each rising edge.
module tb_clk_sync_lockstep;

`ifdef CLK_SYNC_ATK_EN
  localparam logic ATK_SKEW_EXP = 1'b0;
`else
  localparam logic ATK_SKEW_EXP = 1'b1;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic retire_1_i = 1'b0;
  logic retire_2_i = 1'b0;
  logic clk_1_o, clk_2_o, retire_o, finished_o, atk_equiv_o;

  int n_checks = 0;
  int n_pass   = 0;

  clk_sync_lockstep #(.MAX_RETIRES(3)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .retire_1_i  (retire_1_i),
    .retire_2_i  (retire_2_i),
    .clk_1_o     (clk_1_o),
    .clk_2_o     (clk_2_o),
    .retire_o    (retire_o),
    .finished_o  (finished_o),
    .atk_equiv_o (atk_equiv_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic exp4(input string tag, input logic c1, input logic c2,
                      input logic ret, input logic fin);
    check({tag, "_clk1"},     32'(clk_1_o),    32'(c1));
    check({tag, "_clk2"},     32'(clk_2_o),    32'(c2));
    check({tag, "_retire"},   32'(retire_o),   32'(ret));
    check({tag, "_finished"}, 32'(finished_o), 32'(fin));
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    retire_1_i = 1'b0;
    retire_2_i = 1'b0;
    tick();
    exp4({tag, "_rst"}, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_rst_atk"}, 32'(atk_equiv_o), 32'd1);
    rst_i = 1'b0;
  endtask

  initial begin
    int pulses;

    // Idle after reset: clocks rise together on the first edge, then toggle in phase.
    do_reset("idle");
    for (int i = 0; i < 10; i++) begin
      tick();
      exp4("idle", (i % 2) == 0, (i % 2) == 0, 1'b0, 1'b0);
      check("idle_atk", 32'(atk_equiv_o), 32'd1);
    end

    // Simultaneous retirement in the same high phase.
    do_reset("pair");
    tick();
    exp4("pair_hi", 1'b1, 1'b1, 1'b0, 1'b0);
    retire_1_i = 1'b1; retire_2_i = 1'b1;
    tick();
    exp4("pair_pulse", 1'b0, 1'b0, 1'b1, 1'b0);
    retire_1_i = 1'b0; retire_2_i = 1'b0;
    tick();
    exp4("pair_after", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    exp4("pair_after2", 1'b0, 1'b0, 1'b0, 1'b0);
    check("pair_atk", 32'(atk_equiv_o), 32'd1);

    // Core 1 retires, core 2 follows three core cycles later.
    do_reset("skew");
    tick();
    exp4("skew_hi", 1'b1, 1'b1, 1'b0, 1'b0);
    retire_1_i = 1'b1;
    tick();
    exp4("skew_t2", 1'b0, 1'b0, 1'b0, 1'b0);
    retire_1_i = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      tick();
      exp4("skew_stall", 1'b0, (k % 2) == 1, 1'b0, 1'b0);
    end
    retire_2_i = 1'b1;
    tick();
    exp4("skew_pulse", 1'b0, 1'b0, 1'b1, 1'b0);
    retire_2_i = 1'b0;
    tick();
    exp4("skew_realign", 1'b1, 1'b1, 1'b0, 1'b0);
    check("skew_atk", 32'(atk_equiv_o), 32'(ATK_SKEW_EXP));
    tick();
    exp4("skew_realign2", 1'b0, 1'b0, 1'b0, 1'b0);

    // retire_1_i held high across the whole stall: exactly one pulse.
    do_reset("hold");
    pulses = 0;
    tick();
    exp4("hold_hi", 1'b1, 1'b1, 1'b0, 1'b0);
    retire_1_i = 1'b1;
    tick();
    pulses += int'(retire_o);
    exp4("hold_t2", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    pulses += int'(retire_o);
    exp4("hold_t3", 1'b0, 1'b1, 1'b0, 1'b0);
    retire_2_i = 1'b1;
    tick();
    pulses += int'(retire_o);
    exp4("hold_pulse", 1'b0, 1'b0, 1'b1, 1'b0);
    retire_1_i = 1'b0; retire_2_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      pulses += int'(retire_o);
    end
    check("hold_pulse_count", 32'(pulses), 32'd1);

    // Three pairs reach MAX_RETIRES; a fourth strobe is ignored.
    do_reset("fin");
    for (int p = 0; p < 3; p++) begin
      tick();
      exp4("fin_hi", 1'b1, 1'b1, 1'b0, 1'b0);
      retire_1_i = 1'b1; retire_2_i = 1'b1;
      tick();
      exp4("fin_pulse", 1'b0, 1'b0, 1'b1, 1'b0);
      retire_1_i = 1'b0; retire_2_i = 1'b0;
    end
    tick();
    exp4("fin_set", 1'b0, 1'b0, 1'b0, 1'b1);
    retire_1_i = 1'b1; retire_2_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp4("fin_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    retire_1_i = 1'b0; retire_2_i = 1'b0;

    // Reset while core 1 is stalled, with core 2 strobing on the reset edge.
    do_reset("abort");
    tick();
    retire_1_i = 1'b1;
    tick();
    exp4("abort_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    retire_1_i = 1'b0;
    tick();
    exp4("abort_c2hi", 1'b0, 1'b1, 1'b0, 1'b0);
    retire_2_i = 1'b1; rst_i = 1'b1;
    tick();
    exp4("abort_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_rst_atk", 32'(atk_equiv_o), 32'd1);
    retire_2_i = 1'b0; rst_i = 1'b0;
    tick();
    exp4("abort_post1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    exp4("abort_post2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset on the same edge as a paired sample: no pulse may appear.
    do_reset("rpulse");
    tick();
    retire_1_i = 1'b1; retire_2_i = 1'b1; rst_i = 1'b1;
    tick();
    exp4("rpulse_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    retire_1_i = 1'b0; retire_2_i = 1'b0; rst_i = 1'b0;
    tick();
    exp4("rpulse_post", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_sync_lockstep.md
CLK_SYNC_LOCKSTEP -- requirements
Module: clk_sync

Interface
REQ-001 SHALL have parameter MAX_RETIRES, default 32, meaning the number of paired retirements after which both core clocks stop.
REQ-002 SHALL have port clk_i  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port retire_1_i  input  1  core 1 retirement strobe, valid while clk_1_o is high.
REQ-005 SHALL have port retire_2_i  input  1  core 2 retirement strobe, valid while clk_2_o is high.
REQ-006 SHALL have port clk_1_o  output  1  gated half-rate clock for core 1, driven directly from a register.
REQ-007 SHALL have port clk_2_o  output  1  gated half-rate clock for core 2, driven directly from a register.
REQ-008 SHALL have port retire_o  output  1  one-cycle pulse marking one paired retirement of both cores.
REQ-009 SHALL have port finished_o  output  1  sticky flag; MAX_RETIRES paired retirements reached.
REQ-010 SHALL have port atk_equiv_o  output  1  sticky flag; the two core clock waveforms have been identical since reset.

Function
REQ-011 Per core n, SHALL hold registers clk_n (drives clk_n_o) and wait_n (core retired and stalled, waiting for its partner).
REQ-012 Core n running: not wait_n, not finished_o; clk_n SHALL toggle every clk_i cycle, so one core cycle is 2 clk_i cycles.
REQ-013 Core n stalled: wait_n or finished_o; clk_n SHALL be forced to 0 and held low.
REQ-014 Retire sample for core n SHALL occur on a clk_i edge where clk_n==1, wait_n==0 and retire_n_i==1.
REQ-015 Both cores sampled on the same edge: retire_o SHALL be 1 in the next cycle, and neither wait flag SHALL be set.
REQ-016 Only core n sampled: wait_n SHALL be set, and clk_n SHALL fall to 0 and stay low.
REQ-017 Core m sampled while wait_n==1: retire_o SHALL pulse in the next cycle and wait_n SHALL clear.
REQ-018 After a pair completes, both clocks SHALL be 0 and SHALL rise together on the following edge, restoring phase alignment.
REQ-019 retire_n_i SHALL be ignored while wait_n==1.
REQ-020 retire_o SHALL be a registered signal, high for exactly one clk_i cycle per pair, and never high in two consecutive cycles.
REQ-021 A 16-bit counter SHALL increment on each retire_o pulse and saturate at MAX_RETIRES.
REQ-022 finished_o SHALL rise in the cycle after the counter reaches MAX_RETIRES, and SHALL stay 1 until reset.
REQ-023 Once finished_o==1, both clocks SHALL remain low and retire_o SHALL remain 0.
REQ-024 atk_equiv_o SHALL clear permanently on any edge where the registered clk_1 != clk_2.
REQ-025 Deadlock (one core waiting forever) is not resolved by this block; the waiting core SHALL stay stalled.

Reset
REQ-026 rst_i==1 at an edge SHALL force the following on the next cycle: clk_1 = clk_2 = 0, wait flags 0, retire_o 0, counter 0, finished_o 0, atk_equiv_o 1.
REQ-027 Reset mid-stall or mid-pulse SHALL abort it; no retire_o pulse SHALL follow the reset.
REQ-028 On the first edge after reset is deasserted, both clocks SHALL rise in phase.

Configuration
REQ-029 Macro CLK_SYNC_ATK_EN: when defined, the atk_equiv_o comparison logic per REQ-024 SHALL be compiled in.
REQ-030 When CLK_SYNC_ATK_EN is undefined, atk_equiv_o SHALL remain present and SHALL be tied constant 1.

Verification
REQ-031 Reset, then no retires for 10 cycles -> clk_1_o == clk_2_o == 0,1,0,1,...; retire_o = 0; atk_equiv_o = 1.
REQ-032 Both retire strobes high in the same high phase -> retire_o pulses 1 cycle later, width 1; clocks stay aligned; atk_equiv_o = 1.
REQ-033 retire_1_i in phase k, retire_2_i 3 core cycles later -> clk_1_o low for 6 clk_i cycles; then retire_o pulses once; clocks realign; atk_equiv_o = 0 (macro defined) or 1 (macro undefined).
REQ-034 MAX_RETIRES = 3, three paired retirements -> finished_o = 1 the cycle after the third pulse; both clocks low thereafter; a fourth strobe gives no pulse.
REQ-035 rst_i asserted while wait_1 == 1 -> next cycle all state per REQ-026; no stray retire_o pulse.
REQ-036 retire_1_i held high throughout a stall -> exactly one retire_o pulse when core 2 retires.
